// File: rtl/tmip_gray_frontend.sv
// Input front-end for the template-matching image processor.
// Accepts a serial R,G,B byte stream plus a 3x3 template stream, and emits
// one addressed write per pixel carrying the max / average / weighted
// grayscale values. The image dimension is latched per frame and clamped
// to 2**MAX_LOG2. A frame ended early by in_valid dropping is abandoned
// without writing its incomplete pixel.
module tmip_gray_frontend #(
    parameter int  DATA_W   = 8,
    parameter int  SIZE_W   = 2,
    parameter int  MAX_LOG2 = 4,
    localparam int ADDR_W   = 2 * MAX_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     image,
    input  logic [DATA_W-1:0]     template,
    input  logic [SIZE_W-1:0]     image_size,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_max,
    output logic [DATA_W-1:0]     wr_avg,
    output logic [DATA_W-1:0]     wr_wgt,
    output logic [9*DATA_W-1:0]   tpl_out,
    output logic                  tpl_valid,
    output logic [MAX_LOG2-1:0]   dim_log2,
    output logic                  busy,
    output logic                  frame_done
);

    // state | meaning
    // IDLE  | waiting for the first in_valid cycle of a frame
    // LOAD  | streaming bytes of the current frame
    typedef enum logic {IDLE, LOAD} state_t;

    state_t              state, state_nxt;
    logic [1:0]          chan;
    logic [ADDR_W-1:0]   pix;
    logic [ADDR_W-1:0]   last_pix;
    logic [3:0]          tpl_idx;
    logic [DATA_W-1:0]   r_q, g_q;
    logic                frame_start, accept, frame_end;
    logic [MAX_LOG2-1:0] dim_req;
    logic [DATA_W+1:0]   sum;
    logic [DATA_W-1:0]   max_rg, max_rgb, avg, wgt;

    assign busy = (state == LOAD);

    // last pixel index of the latched dimension: dim^2 - 1
    assign last_pix = ~({ADDR_W{1'b1}} << {dim_log2, 1'b0});

    // requested dimension, clamped to the largest supported size
    always_comb begin
        dim_req = MAX_LOG2'(MAX_LOG2);
        if ((32'(image_size) + 32'd2) < 32'(MAX_LOG2))
            dim_req = MAX_LOG2'(32'(image_size) + 32'd2);
    end

    // grayscale arithmetic on registered R,G and the incoming B byte
    always_comb begin
        max_rg  = (r_q > g_q) ? r_q : g_q;
        max_rgb = (max_rg > image) ? max_rg : image;
        sum     = {2'b00, r_q} + {2'b00, g_q} + {2'b00, image};
        avg     = DATA_W'(sum / 3);
        wgt     = (r_q >> 2) + (g_q >> 1) + (image >> 2);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state and per-cycle strobes
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        accept      = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    frame_start = 1'b1;
                    state_nxt   = LOAD;
                end
            end
            LOAD: begin
                if (!in_valid) begin
                    state_nxt = IDLE;
                end else begin
                    accept = 1'b1;
                    if (chan == 2'd2 && pix == last_pix) begin
                        frame_end = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // byte capture, template capture, counters and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            chan       <= '0;
            pix        <= '0;
            tpl_idx    <= '0;
            r_q        <= '0;
            g_q        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_max     <= '0;
            wr_avg     <= '0;
            wr_wgt     <= '0;
            tpl_out    <= '0;
            tpl_valid  <= 1'b0;
            dim_log2   <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            // valid one cycle after entry 8 lands; a new frame clears it
            tpl_valid  <= !frame_start && (tpl_idx == 4'd9);

            if (frame_start) begin
                dim_log2            <= dim_req;
                r_q                 <= image;
                chan                <= 2'd1;
                pix                 <= '0;
                tpl_out[0 +: DATA_W] <= template;
                tpl_idx             <= 4'd1;
            end else if (accept) begin
                if (tpl_idx < 4'd9) begin
                    tpl_out[tpl_idx*DATA_W +: DATA_W] <= template;
                    tpl_idx <= tpl_idx + 4'd1;
                end
                case (chan)
                    2'd0: begin
                        r_q  <= image;
                        chan <= 2'd1;
                    end
                    2'd1: begin
                        g_q  <= image;
                        chan <= 2'd2;
                    end
                    default: begin
                        chan       <= 2'd0;
                        wr_en      <= 1'b1;
                        wr_addr    <= pix;
                        wr_max     <= max_rgb;
                        wr_avg     <= avg;
                        wr_wgt     <= wgt;
                        frame_done <= frame_end;
                        pix        <= frame_end ? '0 : pix + ADDR_W'(1);
                    end
                endcase
            end else if (state == LOAD) begin
                // abort: drop the partial pixel; template entries are kept
                chan <= '0;
                pix  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tmip_gray_frontend.sv
// Randomised bench for tmip_gray_frontend with a queue-based reference model.
module tb_tmip_gray_frontend;

    localparam int DATA_W   = 8;
    localparam int SIZE_W   = 2;
    localparam int MAX_LOG2 = 4;
    localparam int ADDR_W   = 2 * MAX_LOG2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [DATA_W-1:0]    image;
    logic [DATA_W-1:0]    template;
    logic [SIZE_W-1:0]    image_size;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_max, wr_avg, wr_wgt;
    logic [9*DATA_W-1:0]  tpl_out;
    logic                 tpl_valid;
    logic [MAX_LOG2-1:0]  dim_log2;
    logic                 busy;
    logic                 frame_done;

    tmip_gray_frontend #(.DATA_W(DATA_W), .SIZE_W(SIZE_W), .MAX_LOG2(MAX_LOG2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .image(image),
        .template(template), .image_size(image_size), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_max(wr_max), .wr_avg(wr_avg), .wr_wgt(wr_wgt),
        .tpl_out(tpl_out), .tpl_valid(tpl_valid), .dim_log2(dim_log2),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int mx;
        int avg;
        int wgt;
        bit last;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   wr_cnt   = 0;
    int   last_addr = -1;
    int   got_max[256], got_avg[256], got_wgt[256];
    logic [7:0] pr[256], pg[256], pb[256], tpl[9];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    // write monitor: every write must match the head of the model queue
    always @(negedge clk) begin
        exp_t e;
        if (wr_en === 1'b1) begin
            wr_cnt++;
            last_addr = int'(wr_addr);
            got_max[wr_addr] = int'(wr_max);
            got_avg[wr_addr] = int'(wr_avg);
            got_wgt[wr_addr] = int'(wr_wgt);
            if (frame_done === 1'b1) done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 128'(wr_en), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 128'(wr_addr), 128'(e.addr));
                check("wr_max", 128'(wr_max), 128'(e.mx));
                check("wr_avg", 128'(wr_avg), 128'(e.avg));
                check("wr_wgt", 128'(wr_wgt), 128'(e.wgt));
                check("frame_done", 128'(frame_done), 128'(e.last));
                check("wr_latency", 128'(cyc), 128'(e.due));
            end
        end else if (frame_done === 1'b1) begin
            check("done_without_wr", 128'(frame_done), 128'(0));
        end
    end

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            pr[i] = 8'($urandom);
            pg[i] = 8'($urandom);
            pb[i] = 8'($urandom);
        end
        for (int j = 0; j < 9; j++) tpl[j] = 8'($urandom);
    endtask

    // drive one frame (nbytes < 0 means the whole frame) and feed the model
    task automatic send_frame(input int code, input int nbytes, input bit keep_valid);
        int dl, dim, full, n, p, r, g, b, m;
        exp_t e;
        logic [9*DATA_W-1:0] tpl_exp;
        dl   = (2 + code > MAX_LOG2) ? MAX_LOG2 : 2 + code;
        dim  = 1 << dl;
        full = 3 * dim * dim;
        n    = (nbytes < 0) ? full : nbytes;
        for (int j = 0; j < 9; j++) tpl_exp[j*DATA_W +: DATA_W] = tpl[j];
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("dim_log2", 128'(dim_log2), 128'(dl));
                check("busy_in_frame", 128'(busy), 128'(1));
            end
            if (k == 9)  check("tpl_valid_c9", 128'(tpl_valid), 128'(0));
            if (k == 10) begin
                check("tpl_valid_c10", 128'(tpl_valid), 128'(1));
                check("tpl_out", 128'(tpl_out), 128'(tpl_exp));
            end
            p = k / 3;
            in_valid   = 1'b1;
            image      = (k % 3 == 0) ? pr[p] : (k % 3 == 1) ? pg[p] : pb[p];
            image_size = (k == 0) ? SIZE_W'(code) : SIZE_W'($urandom);
            template   = (k < 9) ? tpl[k] : 8'($urandom);
            if (k % 3 == 2) begin
                r = int'(pr[p]); g = int'(pg[p]); b = int'(pb[p]);
                m = (r > g) ? r : g;
                e.addr = p;
                e.mx   = (m > b) ? m : b;
                e.avg  = (r + g + b) / 3;
                e.wgt  = r / 4 + g / 2 + b / 4;
                e.last = (k == full - 1);
                e.due  = cyc + 1;
                exp_q.push_back(e);
            end
        end
        if (!keep_valid) begin
            @(negedge clk);
            in_valid = 1'b0;
            image    = 8'($urandom);
            template = 8'($urandom);
        end
    endtask

    initial begin
        int d;
        logic [9*DATA_W-1:0] tpl_exp;
        rst = 1'b1; in_valid = 1'b0; image = '0; template = '0; image_size = '0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", 128'(wr_en), 128'(0));
        check("rst_wr_addr", 128'(wr_addr), 128'(0));
        check("rst_data", 128'({wr_max, wr_avg, wr_wgt}), 128'(0));
        check("rst_tpl_out", 128'(tpl_out), 128'(0));
        check("rst_tpl_valid", 128'(tpl_valid), 128'(0));
        check("rst_dim_log2", 128'(dim_log2), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_frame_done", 128'(frame_done), 128'(0));
        rst = 1'b0;

        // directed 4x4 frame of (10,20,30), template 1..9
        for (int i = 0; i < 256; i++) begin pr[i] = 8'd10; pg[i] = 8'd20; pb[i] = 8'd30; end
        for (int j = 0; j < 9; j++) tpl[j] = 8'(j + 1);
        wr_cnt = 0;
        send_frame(0, -1, 1'b0);
        repeat (4) @(negedge clk);
        for (int j = 0; j < 9; j++) tpl_exp[j*DATA_W +: DATA_W] = 8'(j + 1);
        check("t1_writes", 128'(wr_cnt), 128'(16));
        check("t1_last_addr", 128'(last_addr), 128'(15));
        check("t1_max", 128'(got_max[7]), 128'(30));
        check("t1_avg", 128'(got_avg[7]), 128'(20));
        check("t1_wgt", 128'(got_wgt[7]), 128'(19));
        check("t1_tpl_hold", 128'(tpl_out), 128'(tpl_exp));
        check("t1_tpl_valid", 128'(tpl_valid), 128'(1));
        check("t1_busy_idle", 128'(busy), 128'(0));
        check("t1_done_cnt", 128'(done_cnt), 128'(1));

        // extremes
        fill_random();
        pr[0] = 8'd255; pg[0] = 8'd255; pb[0] = 8'd255;
        pr[1] = 8'd0;   pg[1] = 8'd0;   pb[1] = 8'd1;
        pr[2] = 8'd3;   pg[2] = 8'd0;   pb[2] = 8'd0;
        send_frame(0, -1, 1'b0);
        repeat (3) @(negedge clk);
        check("ext_ff_max", 128'(got_max[0]), 128'(255));
        check("ext_ff_avg", 128'(got_avg[0]), 128'(255));
        check("ext_ff_wgt", 128'(got_wgt[0]), 128'(253));
        check("ext_001_max", 128'(got_max[1]), 128'(1));
        check("ext_001_avg", 128'(got_avg[1]), 128'(0));
        check("ext_001_wgt", 128'(got_wgt[1]), 128'(0));
        check("ext_300_max", 128'(got_max[2]), 128'(3));
        check("ext_300_avg", 128'(got_avg[2]), 128'(1));
        check("ext_300_wgt", 128'(got_wgt[2]), 128'(0));

        // clamp: code 3 requests 32x32, limited to 16x16
        fill_random();
        wr_cnt = 0;
        send_frame(3, -1, 1'b0);
        repeat (3) @(negedge clk);
        check("clamp_writes", 128'(wr_cnt), 128'(256));
        check("clamp_last_addr", 128'(last_addr), 128'(255));
        check("clamp_dim_log2", 128'(dim_log2), 128'(4));

        // abort after 5 bytes of an 8x8 frame
        fill_random();
        wr_cnt = 0;
        d = done_cnt;
        send_frame(1, 5, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_writes", 128'(wr_cnt), 128'(1));
        check("abort_addr", 128'(last_addr), 128'(0));
        check("abort_tpl_valid", 128'(tpl_valid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_no_done", 128'(done_cnt), 128'(d));

        // back-to-back 8x8 then 4x4
        fill_random();
        wr_cnt = 0;
        d = done_cnt;
        send_frame(1, -1, 1'b1);
        fill_random();
        send_frame(0, -1, 1'b0);
        repeat (3) @(negedge clk);
        check("b2b_writes", 128'(wr_cnt), 128'(80));
        check("b2b_done", 128'(done_cnt), 128'(d + 2));
        check("b2b_dim_log2", 128'(dim_log2), 128'(2));

        // randomised frames
        repeat (4) begin
            fill_random();
            send_frame(int'($urandom_range(0, 3)), -1, ($urandom_range(0, 1) == 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the middle of a 16x16 frame
        fill_random();
        send_frame(2, 100, 1'b1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; image = pr[33]; template = 8'($urandom);
        @(negedge clk);
        check("mrst_wr_en", 128'(wr_en), 128'(0));
        check("mrst_wr_out", 128'({wr_addr, wr_max, wr_avg, wr_wgt}), 128'(0));
        check("mrst_tpl_out", 128'(tpl_out), 128'(0));
        check("mrst_tpl_valid", 128'(tpl_valid), 128'(0));
        check("mrst_dim_log2", 128'(dim_log2), 128'(0));
        check("mrst_busy", 128'(busy), 128'(0));
        check("mrst_frame_done", 128'(frame_done), 128'(0));
        check("mrst_pending", 128'(exp_q.size()), 128'(0));
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        fill_random();
        send_frame(0, -1, 1'b0);
        repeat (5) @(negedge clk);
        check("end_pending", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tmip_gray_frontend.md
# tmip_gray_frontend

Parametrised input front-end for the template-matching image processor. It accepts the serial RGB image stream and the 3x3 template stream, and computes all three grayscale conversions (max, average, weighted) for each pixel. Each pixel's results are written to the downstream frame buffers as one addressed write. It generalises the fixed 4/8/16 input stage: data width and maximum image dimension are parameters, oversize requests are clamped, and aborted frames are handled explicitly.

## Interface

- DATA_W, 8, width of each colour byte, template entry and grayscale result
- SIZE_W, 2, width of the `image_size` code
- MAX_LOG2, 4, log2 of the largest supported image dimension (16 means 16x16)
- ADDR_W, 2*MAX_LOG2, pixel-address width (derived, not overridable)

- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  high for every cycle of an input frame
- image  in  DATA_W  colour byte, sent in R, G, B order per pixel, raster order
- template  in  DATA_W  template entry; valid on the first 9 cycles of a frame
- image_size  in  SIZE_W  dimension code; sampled on the first frame cycle only
- wr_en  out  1  one-cycle write strobe for one pixel
- wr_addr  out  ADDR_W  raster pixel index, row*dim + col
- wr_max  out  DATA_W  max(R,G,B)
- wr_avg  out  DATA_W  floor((R+G+B)/3)
- wr_wgt  out  DATA_W  floor(R/4) + floor(G/2) + floor(B/4)
- tpl_out  out  9*DATA_W  template entry k at bits [k*DATA_W +: DATA_W]
- tpl_valid  out  1  all 9 template entries of the current frame are captured
- dim_log2  out  MAX_LOG2  log2 of the active dimension, latched per frame
- busy  out  1  a frame is in progress
- frame_done  out  1  one-cycle pulse coinciding with the last pixel's wr_en

## Operation

- States: IDLE, LOAD.
  - IDLE -> LOAD on the first cycle with `in_valid`=1.
  - LOAD -> IDLE after the last byte of the frame, or on an abort.
- Frame start (the first `in_valid` cycle in IDLE):
  - `dim_log2` = min(2 + `image_size`, MAX_LOG2). Codes above the maximum are silently clamped.
  - `tpl_valid` clears and the template index resets to 0.
  - The byte on `image` is R of pixel 0.
- Frame length is 3 * dim^2 bytes.
  - A channel counter cycles 0, 1, 2.
  - A pixel counter runs 0 to dim^2 - 1.
- Template capture:
  - Frame cycles 0..8 write `template` into `tpl_out` entry 0..8.
  - `tpl_valid` rises the cycle after entry 8 is captured.
  - Entries hold until the next frame's cycle 0 overwrites them.
  - `template` is ignored after cycle 8.
- Grayscale computation:
  - Performed when the B byte (channel 2) is accepted, using the registered R and G.
  - The R+G+B sum is DATA_W+2 bits wide; `wr_avg` uses floor division.
  - `wr_wgt` never exceeds 2^DATA_W - 1, so no saturation is needed.
- Write outputs:
  - Registered; `wr_en` is high for exactly one cycle per pixel.
  - `wr_addr`, `wr_max`, `wr_avg` and `wr_wgt` are valid only while `wr_en`=1.
- End of frame:
  - After the last B byte, return to IDLE.
  - If `in_valid` is still high on the next cycle, that cycle starts a new frame: `image_size` is resampled and the template is recaptured.
- Abort (`in_valid`=0 in LOAD before the frame is complete):
  - Return to IDLE and clear all counters.
  - An incomplete pixel is never written.
  - `frame_done` does not pulse.
  - The template entries captured so far are kept, but `tpl_valid` stays 0 unless all 9 were captured.

## Timing

- Reset values: every output is 0, including all `tpl_out` entries; state is IDLE.
- Reset has priority over every other event, including reset asserted mid-frame. No write is issued in the cycle after reset.
- Latency: a B byte accepted at edge t produces `wr_en`=1 with that pixel's data during the following cycle (valid after edge t+1).
- `frame_done` is asserted in the same cycle as the `wr_en` for pixel dim^2 - 1.
- `busy` is 1 from the first frame cycle through the cycle of the last byte, and 0 in IDLE.
- Throughput: no backpressure.
  - Every `in_valid` cycle consumes one byte.
  - Writes are spaced at least 3 cycles apart.
- `dim_log2` updates at frame start (visible in the following cycle) and holds until the next frame start.

## Test plan

- 4x4 frame (`image_size`=0), every pixel (R,G,B) = (10,20,30), template entries 1..9:
  - 16 writes to addresses 0..15, each with max=30, avg=20, wgt=19.
  - `tpl_out` holds 1..9; `tpl_valid`=1 from frame cycle 10.
  - `frame_done` pulses with the 16th write, about 49 cycles after frame start.
- Extremes at DATA_W=8:
  - Pixel (255,255,255) gives max=255, avg=255, wgt=253.
  - Pixel (0,0,1) gives max=1, avg=0, wgt=0.
  - Pixel (3,0,0) gives max=3, avg=1, wgt=0.
- Clamp: MAX_LOG2=4, `image_size`=3 -> `dim_log2`=4, 768 input cycles, 256 writes, last `wr_addr`=255.
- Abort: drop `in_valid` after 5 bytes of an 8x8 frame:
  - Exactly one write (address 0), no `frame_done`, `tpl_valid`=0, `busy` returns to 0.
  - The next frame's first write goes to address 0.
- Back-to-back frames: an 8x8 frame immediately followed by a 4x4 frame with `in_valid` continuous:
  - 64 then 16 writes, and `dim_log2` goes 3 then 2.
  - The template reloads on the second frame's first 9 cycles.
- Reset mid-frame: assert `rst` at byte 100 of a 16x16 frame:
  - The next cycle shows all outputs 0 and `busy`=0.
  - A fresh frame afterwards starts writes at address 0.
